id_ex_stage: RTL

ID/EX pipeline register for the 5-stage MIPS core, sitting directly downstream of the register file. Each cycle it captures the decoded instruction: register read data, sign-extended immediate, register indices and control bits. It presents them, registered, to the execute stage. It also detects load-use hazards, stalls the front end and inserts a bubble. It honours branch flushes and keeps a saturating count of inserted load-use bubbles.

---
 rtl/mips_pipe_pkg.sv | 42 ++++
 rtl/id_ex_stage_hazard_detect.sv | 20 ++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline registers: the control bundle layout,
// default widths and the ALUOp encodings.
package mips_pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_CTRL_W = 8;

    // Control bundle bit positions, MSB first:
    // {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[1:0]}
    localparam int CTRL_REGWRITE_BIT = 7;
    localparam int CTRL_MEMREAD_BIT  = 6;
    localparam int CTRL_MEMWRITE_BIT = 5;
    localparam int CTRL_MEMTOREG_BIT = 4;
    localparam int CTRL_ALUSRC_BIT   = 3;
    localparam int CTRL_REGDST_BIT   = 2;
    localparam int CTRL_ALUOP_MSB    = 1;
    localparam int CTRL_ALUOP_LSB    = 0;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,  // loads/stores: address add
        ALUOP_SUB   = 2'b01,  // branches: compare by subtract
        ALUOP_FUNCT = 2'b10,  // R-type: operation from funct field
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   mem_to_reg;
        logic   alu_src;
        logic   reg_dst;
        aluop_e alu_op;
    } ctrl_t;

    // Extract the MemRead bit from a raw control bundle.
    function automatic logic ctrl_mem_read(input logic [DEF_CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD_BIT];
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags when the load sitting in EX writes a
// register that the instruction in ID reads. Writes to $zero never hazard.
module hazard_detect
    import mips_pipe_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
)(
    input  logic              i_ex_valid,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    output logic              o_hazard
);

    assign o_hazard = i_ex_valid & i_ex_mem_read & (i_ex_rt != {REG_AW{1'b0}}) & i_id_valid &
                      ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and a saturating
// bubble counter. Optional build macro WB_BYPASS_EN forwards same-cycle
// writeback data into the captured operands.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CTRL_W = DEF_CTRL_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [15:0]       hazard_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic              r_ex_valid;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic [REG_AW-1:0] r_ex_rd;
    logic [DATA_W-1:0] r_ex_rs_data;
    logic [DATA_W-1:0] r_ex_rt_data;
    logic [DATA_W-1:0] r_ex_imm;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [15:0]       r_hazard_cnt;

    logic              w_hazard;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .i_ex_valid    (r_ex_valid),
        .i_ex_mem_read (r_ex_ctrl[CTRL_MEMREAD_BIT]),
        .i_ex_rt       (r_ex_rt),
        .i_id_valid    (id_valid),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .o_hazard      (w_hazard)
    );

    // A flush squashes the younger instruction, so it must not also freeze the front end.
    assign stall = w_hazard & ~flush;

`ifndef WB_BYPASS_EN
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_regwrite, wb_reg, wb_data};
`endif

    // Operand select: optional writeback bypass, then the $zero override on top.
    always_comb begin
        w_rs_data = id_rs_data;
        w_rt_data = id_rt_data;
`ifdef WB_BYPASS_EN
        if (wb_regwrite && (wb_reg != {REG_AW{1'b0}}) && (wb_reg == id_rs)) begin
            w_rs_data = wb_data;
        end else begin
            w_rs_data = id_rs_data;
        end
        if (wb_regwrite && (wb_reg != {REG_AW{1'b0}}) && (wb_reg == id_rt)) begin
            w_rt_data = wb_data;
        end else begin
            w_rt_data = id_rt_data;
        end
`endif
        if (id_rs == {REG_AW{1'b0}}) begin
            w_rs_data = {DATA_W{1'b0}};
        end else begin
            w_rs_data = w_rs_data;
        end
        if (id_rt == {REG_AW{1'b0}}) begin
            w_rt_data = {DATA_W{1'b0}};
        end else begin
            w_rt_data = w_rt_data;
        end
    end

    // Pipeline register: flush beats hazard bubble beats normal capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_valid   <= 1'b0;
            r_ex_rs      <= {REG_AW{1'b0}};
            r_ex_rt      <= {REG_AW{1'b0}};
            r_ex_rd      <= {REG_AW{1'b0}};
            r_ex_rs_data <= {DATA_W{1'b0}};
            r_ex_rt_data <= {DATA_W{1'b0}};
            r_ex_imm     <= {DATA_W{1'b0}};
            r_ex_ctrl    <= {CTRL_W{1'b0}};
        end else if (flush || w_hazard) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= {CTRL_W{1'b0}};
        end else begin
            r_ex_valid   <= id_valid;
            r_ex_ctrl    <= id_valid ? id_ctrl : {CTRL_W{1'b0}};
            r_ex_rs      <= id_rs;
            r_ex_rt      <= id_rt;
            r_ex_rd      <= id_rd;
            r_ex_rs_data <= w_rs_data;
            r_ex_rt_data <= w_rt_data;
            r_ex_imm     <= id_imm;
        end
    end

    // Saturating count of load-use bubbles; flushed cycles are not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hazard_cnt <= 16'h0000;
        end else if (w_hazard && !flush && (r_hazard_cnt != CNT_MAX)) begin
            r_hazard_cnt <= r_hazard_cnt + 16'h0001;
        end else begin
            r_hazard_cnt <= r_hazard_cnt;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_rs      = r_ex_rs;
    assign ex_rt      = r_ex_rt;
    assign ex_rd      = r_ex_rd;
    assign ex_rs_data = r_ex_rs_data;
    assign ex_rt_data = r_ex_rt_data;
    assign ex_imm     = r_ex_imm;
    assign ex_ctrl    = r_ex_ctrl;
    assign hazard_cnt = r_hazard_cnt;

endmodule
